// File: rtl/qspi_bus_arbiter_pkg.sv
// Shared types and constants for the quad-SPI bus arbiter.
//   arb_state_t     : arbiter FSM states
//   CS_*            : eng_cs encodings (CE0 flash, CE1/CE2 PSRAM)
//   REGION_*        : addr[31:28] region nibbles
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    GAP
  } arb_state_t;

  localparam logic [1:0] CS_FLASH  = 2'd0;
  localparam logic [1:0] CS_PSRAM0 = 2'd1;
  localparam logic [1:0] CS_PSRAM1 = 2'd2;

  localparam logic [3:0] REGION_FLASH = 4'h2;
  localparam logic [3:0] REGION_PSRAM = 4'h8;

endpackage

// File: rtl/qspi_bus_arbiter_if.sv
// Bundle of the two requester ports (m0 = ifetch, m1 = data) and the
// downstream QSPI engine handshake.
//   slave  : arbiter view (requests and eng_ready/eng_rdata in; responses and eng_* requests out)
//   master : environment view (drives requests and the engine response)
interface qspi_bus_arbiter_if;
  import qspi_arb_pkg::*;

  logic        m0_valid;
  logic [31:0] m0_addr;
  logic        m0_ready;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wstrb;
  logic        m1_ready;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        eng_valid;
  logic [1:0]  eng_cs;
  logic [23:0] eng_addr;
  logic [31:0] eng_wdata;
  logic [3:0]  eng_wstrb;
  logic        eng_ready;
  logic [31:0] eng_rdata;

  modport slave (
    input  m0_valid, m0_addr,
    output m0_ready, m0_rdata, m0_err,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata, m1_err,
    output eng_valid, eng_cs, eng_addr, eng_wdata, eng_wstrb,
    input  eng_ready, eng_rdata
  );

  modport master (
    output m0_valid, m0_addr,
    input  m0_ready, m0_rdata, m0_err,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata, m1_err,
    input  eng_valid, eng_cs, eng_addr, eng_wdata, eng_wstrb,
    output eng_ready, eng_rdata
  );

endinterface

// File: rtl/qspi_bus_arbiter_addr_decode.sv
// Combinational address decoder for the arbiter's selected request.
//   addr       : 32-bit byte address
//   is_write   : request carries non-zero byte strobes
//   cs         : chip-select encoding for the engine
//   local_addr : 24-bit device-local address (bit 23 cleared for PSRAM)
//   err        : unmapped region, or write to flash
module qspi_addr_decode
  import qspi_arb_pkg::*;
(
  input  logic [31:0] addr,
  input  logic        is_write,
  output logic [1:0]  cs,
  output logic [23:0] local_addr,
  output logic        err
);

  // addr[27:24] is a don't-care inside both mapped regions
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[27:24];

  always_comb begin
    cs         = CS_FLASH;
    local_addr = '0;
    err        = 1'b0;
    case (addr[31:28])
      REGION_FLASH: begin
        cs         = CS_FLASH;
        local_addr = addr[23:0];
        err        = is_write;
      end
      REGION_PSRAM: begin
        // addr[23] picks the PSRAM die and is not part of the device address
        cs         = addr[23] ? CS_PSRAM1 : CS_PSRAM0;
        local_addr = {1'b0, addr[22:0]};
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Round-robin arbiter sharing one quad-SPI bus between the ifetch (m0)
// and data (m1) ports. One transaction at a time is forwarded to the QSPI
// engine; a CE-high gap of CE_GAP_CYCLES idle cycles follows each engine
// transaction. Decode errors are answered locally without touching the bus.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester ports and engine handshake (slave modport)
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int unsigned CE_GAP_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  qspi_bus_arbiter_if.slave bus
);

  localparam int unsigned GAP_W = (CE_GAP_CYCLES == 0) ? 1 : $clog2(CE_GAP_CYCLES + 1);

  arb_state_t       state_q, state_d;
  logic             last_grant_q;
  logic             cur_q;
  logic             resp_err_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic             any_valid;
  logic             sel;
  logic             grant;
  logic             eng_done;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;
  logic [1:0]       dec_cs;
  logic [23:0]      dec_addr;
  logic             dec_err;

  logic             eng_valid_q;
  logic [1:0]       eng_cs_q;
  logic [23:0]      eng_addr_q;
  logic [31:0]      eng_wdata_q;
  logic [3:0]       eng_wstrb_q;
  logic             m0_ready_q, m0_err_q;
  logic [31:0]      m0_rdata_q;
  logic             m1_ready_q, m1_err_q;
  logic [31:0]      m1_rdata_q;

  // Contention goes to the port that did not win last; a lone requester wins.
  always_comb begin
    any_valid = bus.m0_valid | bus.m1_valid;
    if (bus.m0_valid && bus.m1_valid) sel = ~last_grant_q;
    else                              sel = ~bus.m0_valid;
    req_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    req_wdata = sel ? bus.m1_wdata : '0;
    req_wstrb = sel ? bus.m1_wstrb : '0;
  end

  qspi_addr_decode u_decode (
    .addr       (req_addr),
    .is_write   (|req_wstrb),
    .cs         (dec_cs),
    .local_addr (dec_addr),
    .err        (dec_err)
  );

  assign eng_done = (state_q == BUSY) && bus.eng_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant   = 1'b1;
          state_d = dec_err ? RESP : BUSY;
        end
      end
      BUSY: if (bus.eng_ready) state_d = RESP;
      RESP: state_d = (resp_err_q || CE_GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt_q == GAP_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cur_q        <= 1'b0;
      resp_err_q   <= 1'b0;
      gap_cnt_q    <= '0;
      eng_valid_q  <= 1'b0;
      eng_cs_q     <= '0;
      eng_addr_q   <= '0;
      eng_wdata_q  <= '0;
      eng_wstrb_q  <= '0;
      m0_ready_q   <= 1'b0;
      m0_err_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_ready_q   <= 1'b0;
      m1_err_q     <= 1'b0;
      m1_rdata_q   <= '0;
    end else begin
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;

      if (grant) begin
        last_grant_q <= sel;
        cur_q        <= sel;
        resp_err_q   <= dec_err;
        if (dec_err) begin
          if (sel) begin
            m1_ready_q <= 1'b1;
            m1_err_q   <= 1'b1;
            m1_rdata_q <= '0;
          end else begin
            m0_ready_q <= 1'b1;
            m0_err_q   <= 1'b1;
            m0_rdata_q <= '0;
          end
        end else begin
          eng_valid_q <= 1'b1;
          eng_cs_q    <= dec_cs;
          eng_addr_q  <= dec_addr;
          eng_wdata_q <= req_wdata;
          eng_wstrb_q <= req_wstrb;
        end
      end

      // Completion is routed to the granted port even if it has since dropped valid.
      if (eng_done) begin
        eng_valid_q <= 1'b0;
        if (cur_q) begin
          m1_ready_q <= 1'b1;
          m1_err_q   <= 1'b0;
          m1_rdata_q <= bus.eng_rdata;
        end else begin
          m0_ready_q <= 1'b1;
          m0_err_q   <= 1'b0;
          m0_rdata_q <= bus.eng_rdata;
        end
      end

      if (state_q == RESP)     gap_cnt_q <= GAP_W'(CE_GAP_CYCLES);
      else if (state_q == GAP) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

  assign bus.eng_valid = eng_valid_q;
  assign bus.eng_cs    = eng_cs_q;
  assign bus.eng_addr  = eng_addr_q;
  assign bus.eng_wdata = eng_wdata_q;
  assign bus.eng_wstrb = eng_wstrb_q;
  assign bus.m0_ready  = m0_ready_q;
  assign bus.m0_err    = m0_err_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_ready  = m1_ready_q;
  assign bus.m1_err    = m1_err_q;
  assign bus.m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
module tb_qspi_bus_arbiter;

  localparam int unsigned GAP_A   = 2;
  localparam int unsigned ENG_LAT = 3;
  localparam int unsigned NVEC    = 10;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          exp_err;
    logic [1:0]  exp_cs;
    logic [23:0] exp_laddr;
  } vec_t;

  typedef struct {
    logic [1:0]  cs;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } eng_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;

  vec_t  vecs [NVEC];
  eng_t  eng_q [$];
  resp_t resp0_q [$];
  resp_t resp1_q [$];

  logic        prev_ev = 1'b0;
  logic [61:0] held_q  = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qspi_bus_arbiter_if ifa ();
  qspi_bus_arbiter_if ifb ();

  qspi_bus_arbiter #(.CE_GAP_CYCLES(GAP_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  qspi_bus_arbiter #(.CE_GAP_CYCLES(0))     dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  function automatic logic [31:0] eng_data(input logic [23:0] a);
    return 32'hDEADBEEF ^ {8'h00, a} ^ 32'h0000_0010;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  task automatic exp_eng(input logic [1:0] cs, input logic [23:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
    eng_t e;
    e.cs = cs; e.addr = a; e.wdata = wd; e.wstrb = ws;
    eng_q.push_back(e);
  endtask

  task automatic exp_resp(input bit port, input logic err, input logic [31:0] rd);
    resp_t r;
    r.err = err; r.rdata = rd;
    if (port) resp1_q.push_back(r);
    else      resp0_q.push_back(r);
  endtask

  // which: 0 a.m0_ready, 1 a.m1_ready, 2 a.eng_valid, 3 b.m1_ready, 4 b.eng_valid
  task automatic wait_sig(input int unsigned which, input string name,
                          output bit ok, output int unsigned n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      n++;
      case (which)
        0: ok = ifa.m0_ready;
        1: ok = ifa.m1_ready;
        2: ok = ifa.eng_valid;
        3: ok = ifb.m1_ready;
        default: ok = ifb.eng_valid;
      endcase
    end
    if (!ok) fail(name, "timeout waiting 60 cycles");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int unsigned n;
    if (!v.exp_err) exp_eng(v.exp_cs, v.exp_laddr, v.wdata, v.wstrb);
    exp_resp(v.port, v.exp_err, v.exp_err ? 32'h0 : eng_data(v.exp_laddr));
    @(negedge clk);
    if (v.port) begin
      ifa.m1_addr = v.addr; ifa.m1_wdata = v.wdata; ifa.m1_wstrb = v.wstrb; ifa.m1_valid = 1'b1;
    end else begin
      ifa.m0_addr = v.addr; ifa.m0_valid = 1'b1;
    end
    wait_sig(v.port ? 1 : 0, "vec_ready", ok, n);
    if (ok) check("vec_latency", n, v.exp_err ? 1 : ENG_LAT + 2);
    ifa.m0_valid = 1'b0;
    ifa.m1_valid = 1'b0;
    repeat (GAP_A + 2) @(negedge clk);
  endtask

  // Engine models: ready pulse ENG_LAT cycles after eng_valid is first seen.
  initial begin : eng_model_a
    int unsigned cnt;
    cnt = 0;
    ifa.eng_ready = 1'b0;
    ifa.eng_rdata = '0;
    forever begin
      @(negedge clk);
      if (ifa.eng_ready) ifa.eng_ready = 1'b0;
      else if (ifa.eng_valid) begin
        if (cnt == ENG_LAT) begin
          ifa.eng_ready = 1'b1;
          ifa.eng_rdata = eng_data(ifa.eng_addr);
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  initial begin : eng_model_b
    int unsigned cnt;
    cnt = 0;
    ifb.eng_ready = 1'b0;
    ifb.eng_rdata = '0;
    forever begin
      @(negedge clk);
      if (ifb.eng_ready) ifb.eng_ready = 1'b0;
      else if (ifb.eng_valid) begin
        if (cnt == ENG_LAT) begin
          ifb.eng_ready = 1'b1;
          ifb.eng_rdata = eng_data(ifb.eng_addr);
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Scoreboard monitor for DUT A.
  always @(negedge clk) begin
    if (ifa.eng_valid && !prev_ev) begin
      if (eng_q.size() == 0) fail("eng_unexpected", $sformatf("eng_valid rose, cs=%0d addr=%0h", ifa.eng_cs, ifa.eng_addr));
      else begin
        check("eng_cs", ifa.eng_cs, eng_q[0].cs);
        check("eng_addr", ifa.eng_addr, eng_q[0].addr);
        check("eng_wdata", ifa.eng_wdata, eng_q[0].wdata);
        check("eng_wstrb", ifa.eng_wstrb, eng_q[0].wstrb);
        eng_q.delete(0);
      end
      held_q <= {ifa.eng_cs, ifa.eng_addr, ifa.eng_wdata, ifa.eng_wstrb};
    end else if (ifa.eng_valid) begin
      check("eng_hold", {ifa.eng_cs, ifa.eng_addr, ifa.eng_wdata, ifa.eng_wstrb}, held_q);
    end
    if (ifa.m0_ready) begin
      if (resp0_q.size() == 0) fail("m0_unexpected", "m0_ready=1 required no response");
      else begin
        check("m0_err", ifa.m0_err, resp0_q[0].err);
        check("m0_rdata", ifa.m0_rdata, resp0_q[0].rdata);
        resp0_q.delete(0);
      end
    end
    if (ifa.m1_ready) begin
      if (resp1_q.size() == 0) fail("m1_unexpected", "m1_ready=1 required no response");
      else begin
        check("m1_err", ifa.m1_err, resp1_q[0].err);
        check("m1_rdata", ifa.m1_rdata, resp1_q[0].rdata);
        resp1_q.delete(0);
      end
    end
    prev_ev <= ifa.eng_valid;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          ok;
    int unsigned n, t0, t1, n0, n1;

    //          port  addr          wdata         wstrb  err   cs    local addr
    vecs[0] = '{1'b1, 32'h8000_0010, 32'h0,        4'h0, 1'b0, 2'd1, 24'h000010};
    vecs[1] = '{1'b0, 32'h2012_3456, 32'h0,        4'h0, 1'b0, 2'd0, 24'h123456};
    vecs[2] = '{1'b1, 32'h8080_0004, 32'h1122_3344, 4'hF, 1'b0, 2'd2, 24'h000004};
    vecs[3] = '{1'b1, 32'h2000_0000, 32'hA5A5_A5A5, 4'h1, 1'b1, 2'd0, 24'h000000};
    vecs[4] = '{1'b0, 32'h4000_0000, 32'h0,        4'h0, 1'b1, 2'd0, 24'h000000};
    vecs[5] = '{1'b1, 32'h8FFF_FFFC, 32'h0,        4'h0, 1'b0, 2'd2, 24'h7FFFFC};
    vecs[6] = '{1'b1, 32'h9000_0000, 32'h0,        4'h0, 1'b1, 2'd0, 24'h000000};
    vecs[7] = '{1'b0, 32'h2FFF_FFFF, 32'h0,        4'h0, 1'b0, 2'd0, 24'hFFFFFF};
    vecs[8] = '{1'b1, 32'h8000_0100, 32'h0000_BB00, 4'h2, 1'b0, 2'd1, 24'h000100};
    vecs[9] = '{1'b1, 32'h2000_0040, 32'h0,        4'h0, 1'b0, 2'd0, 24'h000040};

    ifa.m0_valid = 1'b0; ifa.m0_addr = '0;
    ifa.m1_valid = 1'b0; ifa.m1_addr = '0; ifa.m1_wdata = '0; ifa.m1_wstrb = '0;
    ifb.m0_valid = 1'b0; ifb.m0_addr = '0;
    ifb.m1_valid = 1'b0; ifb.m1_addr = '0; ifb.m1_wdata = '0; ifb.m1_wstrb = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m0", {ifa.m0_ready, ifa.m0_err, ifa.m0_rdata}, '0);
    check("rst_m1", {ifa.m1_ready, ifa.m1_err, ifa.m1_rdata}, '0);
    check("rst_eng", {ifa.eng_valid, ifa.eng_cs, ifa.eng_addr, ifa.eng_wdata, ifa.eng_wstrb}, '0);
    check("rst_eng_b", {ifb.eng_valid, ifb.m1_ready, ifb.m0_ready}, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Contention straight after reset: m0 first, then m1 after exactly GAP_A idle cycles.
    pulse_reset();
    exp_eng(2'd0, 24'h000000, 32'h0, 4'h0);
    exp_eng(2'd2, 24'h000004, 32'h0, 4'h0);
    exp_resp(1'b0, 1'b0, eng_data(24'h000000));
    exp_resp(1'b1, 1'b0, eng_data(24'h000004));
    @(negedge clk);
    ifa.m0_addr = 32'h2000_0000; ifa.m0_valid = 1'b1;
    ifa.m1_addr = 32'h8080_0004; ifa.m1_wdata = '0; ifa.m1_wstrb = '0; ifa.m1_valid = 1'b1;
    wait_sig(0, "cont_m0_ready", ok, n);
    t0 = cyc;
    ifa.m0_valid = 1'b0;
    wait_sig(2, "cont_m1_grant", ok, n);
    t1 = cyc;
    if (ok) check("cont_gap", t1 - t0, GAP_A + 2);
    wait_sig(1, "cont_m1_ready", ok, n);
    ifa.m1_valid = 1'b0;
    repeat (GAP_A + 2) @(negedge clk);

    // Fairness: both held valid for six transactions, grants alternate from m0.
    for (int i = 0; i < 3; i++) begin
      exp_eng(2'd0, 24'h000100, 32'h0, 4'h0);
      exp_eng(2'd1, 24'h000200, 32'hCAFE_F00D, 4'hF);
      exp_resp(1'b0, 1'b0, eng_data(24'h000100));
      exp_resp(1'b1, 1'b0, eng_data(24'h000200));
    end
    @(negedge clk);
    ifa.m0_addr = 32'h2000_0100; ifa.m0_valid = 1'b1;
    ifa.m1_addr = 32'h8000_0200; ifa.m1_wdata = 32'hCAFE_F00D; ifa.m1_wstrb = 4'hF; ifa.m1_valid = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 200 && (n0 < 3 || n1 < 3); i++) begin
      @(negedge clk);
      if (ifa.m0_ready) begin n0++; if (n0 == 3) ifa.m0_valid = 1'b0; end
      if (ifa.m1_ready) begin n1++; if (n1 == 3) ifa.m1_valid = 1'b0; end
    end
    check("fair_counts", {n0, n1}, {32'd3, 32'd3});
    ifa.m0_valid = 1'b0; ifa.m1_valid = 1'b0;
    repeat (GAP_A + 2) @(negedge clk);

    // Asynchronous reset in the middle of a bus transaction.
    exp_eng(2'd1, 24'h000040, 32'h0, 4'h0);
    @(negedge clk);
    ifa.m1_addr = 32'h8000_0040; ifa.m1_wdata = '0; ifa.m1_wstrb = '0; ifa.m1_valid = 1'b1;
    wait_sig(2, "abort_busy", ok, n);
    #2 rst_n = 1'b0;
    #1 check("abort_eng_valid", ifa.eng_valid, 1'b0);
    ifa.m1_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_ready", {ifa.m0_ready, ifa.m1_ready}, 2'b00);
    rst_n = 1'b1;
    exp_eng(2'd0, 24'h000008, 32'h0, 4'h0);
    exp_eng(2'd1, 24'h000008, 32'h0, 4'h0);
    exp_resp(1'b0, 1'b0, eng_data(24'h000008));
    exp_resp(1'b1, 1'b0, eng_data(24'h000008));
    @(negedge clk);
    ifa.m0_addr = 32'h2000_0008; ifa.m0_valid = 1'b1;
    ifa.m1_addr = 32'h8000_0008; ifa.m1_valid = 1'b1;
    wait_sig(0, "post_rst_m0", ok, n);
    ifa.m0_valid = 1'b0;
    wait_sig(1, "post_rst_m1", ok, n);
    ifa.m1_valid = 1'b0;
    repeat (GAP_A + 2) @(negedge clk);

    // Zero-gap build: back-to-back m1 reads.
    @(negedge clk);
    ifb.m1_addr = 32'h8000_0020; ifb.m1_wdata = '0; ifb.m1_wstrb = '0; ifb.m1_valid = 1'b1;
    wait_sig(3, "b_ready1", ok, n);
    t0 = cyc;
    if (ok) check("b_rdata1", {ifb.m1_err, ifb.m1_rdata}, {1'b0, eng_data(24'h000020)});
    wait_sig(4, "b_grant2", ok, n);
    t1 = cyc;
    if (ok) begin
      check("b_gap0", t1 - t0, 2);
      check("b_eng", {ifb.eng_cs, ifb.eng_addr}, {2'd1, 24'h000020});
    end
    wait_sig(3, "b_ready2", ok, n);
    if (ok) check("b_rdata2", ifb.m1_rdata, eng_data(24'h000020));
    ifb.m1_valid = 1'b0;
    repeat (4) @(negedge clk);

    check("sb_empty", eng_q.size() + resp0_q.size() + resp1_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
